// File: rtl/imem_loader_pkg.sv
// Shared state encoding and status-flag layout for the instruction-memory loader.
// Defining IMEM_LOADER_CHECKSUM_EN adds the CHECK state for the trailing checksum byte.
package imem_loader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK = 3'd2;
`endif
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK = ST_CHECK,
`endif
    DONE  = ST_DONE,
    ERROR = ST_ERROR
  } state_t;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERROR = 2;
  localparam int STAT_W     = 3;

  typedef logic [STAT_W-1:0] status_t;

  // Status flags are one-hot per state; IDLE shows all zeros.
  function automatic status_t status_of(state_t s);
    status_t st;
    st = '0;
    case (s)
      LOAD:    st[STAT_BUSY]  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK:   st[STAT_BUSY]  = 1'b1;
`endif
      DONE:    st[STAT_DONE]  = 1'b1;
      ERROR:   st[STAT_ERROR] = 1'b1;
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory and holds the core in reset until loading completes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing modulo-256 checksum byte).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 16,
  parameter int MEM_BYTES      = 64,
  parameter int BASE_ADDR      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_BUS_WIDTH-1:0] len,
  input  logic                      abort,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  output logic                      byte_ready,
  output logic                      mem_we,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [7:0]                mem_wdata,
  output logic                      cpu_rst_n,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [ADDR_BUS_WIDTH-1:0] count
);

  // One extra bit so BASE_ADDR+len cannot wrap before the capacity compare.
  localparam int                        XW    = ADDR_BUS_WIDTH + 1;
  localparam logic [ADDR_BUS_WIDTH-1:0] BASE  = ADDR_BUS_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_BUS_WIDTH-1:0] ONE   = ADDR_BUS_WIDTH'(1);
  localparam logic [XW-1:0]             LIMIT = XW'(MEM_BYTES);

  state_t                    state;
  state_t                    state_nxt;
  status_t                   status;
  logic [ADDR_BUS_WIDTH-1:0] len_q;
  logic [ADDR_BUS_WIDTH-1:0] addr_q;
  logic [XW-1:0]             end_addr;
  logic                      idle_like;
  logic                      in_session;
  logic                      start_ok;
  logic                      load_hs;
  logic                      last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]                csum_q;
  logic                      check_hs;
`endif

  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_session = (state == LOAD) || (state == CHECK);
  assign check_hs   = byte_valid && byte_ready && (state == CHECK);
`else
  assign in_session = (state == LOAD);
`endif

  // Abort wins over a byte offered in the same cycle, so it is simply not accepted.
  assign byte_ready = in_session && !abort;
  assign start_ok   = start && idle_like;
  assign load_hs    = byte_valid && byte_ready && (state == LOAD);
  assign last_byte  = (count + ONE) == len_q;
  assign end_addr   = XW'(BASE_ADDR) + XW'(len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          if (len == '0) begin
            state_nxt = DONE;
          end else if (end_addr > LIMIT) begin
            state_nxt = ERROR;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (load_hs && last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (check_hs) begin
          state_nxt = (byte_data == csum_q) ? DONE : ERROR;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Write strobe is registered, giving exactly one cycle from handshake to memory write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      addr_q    <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= load_hs;
      if (start_ok) begin
        len_q  <= len;
        addr_q <= BASE;
        count  <= '0;
      end else if (load_hs) begin
        addr_q    <= addr_q + ONE;
        count     <= count + ONE;
        mem_addr  <= addr_q;
        mem_wdata <= byte_data;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (load_hs) begin
      csum_q <= csum_q + byte_data;
    end
  end
`endif

  assign status    = status_of(state);
  assign busy      = status[STAT_BUSY];
  assign done      = status[STAT_DONE];
  assign error     = status[STAT_ERROR];
  assign cpu_rst_n = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed table, corner sequences and random sessions
// checked against a session-level reference model.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int AW   = 16;
  localparam int MEMB = 64;
  localparam int BASE = 0;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_CHECK = 2;
  localparam int P_DONE  = 3;
  localparam int P_ERR   = 4;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] len;
  logic          abort;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] count;

  imem_loader #(
    .ADDR_BUS_WIDTH(AW),
    .MEM_BYTES     (MEMB),
    .BASE_ADDR     (BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  int         n_writes;
  int         m_phase;
  int         m_count;
  int         m_len;
  int         m_addr;
  logic [7:0] m_sum;
  bit         m_we;
  int         m_waddr;
  logic [7:0] m_wdata;

  typedef struct {
    bit         st;
    int         ln;
    bit         ab;
    bit         v;
    logic [7:0] d;
    bit         e_busy;
    bit         e_done;
    bit         e_err;
    bit         e_we;
    int         e_addr;
    logic [7:0] e_data;
    int         e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Session-level reference: one call per clock edge with the inputs held during that cycle.
  task automatic modelStep(input bit st, input int ln, input bit ab, input bit v, input logic [7:0] d);
    m_we = 1'b0;
    if (m_phase == P_LOAD || m_phase == P_CHECK) begin
      if (ab) begin
        m_phase = P_IDLE;
      end else if (v && m_phase == P_LOAD) begin
        m_we    = 1'b1;
        m_waddr = m_addr;
        m_wdata = d;
        m_addr  = (m_addr + 1) % 65536;
        m_count = (m_count + 1) % 65536;
        m_sum   = m_sum + d;
        if (m_count == m_len) m_phase = CSUM ? P_CHECK : P_DONE;
      end else if (v) begin
        m_phase = (d == m_sum) ? P_DONE : P_ERR;
      end
    end else if (st) begin
      m_count = 0;
      m_sum   = 8'h00;
      m_len   = ln;
      m_addr  = BASE;
      if (ln == 0)                m_phase = P_DONE;
      else if (BASE + ln > MEMB)  m_phase = P_ERR;
      else                        m_phase = P_LOAD;
    end
  endtask

  task automatic modelReset();
    m_phase = P_IDLE;
    m_count = 0;
    m_len   = 0;
    m_addr  = BASE;
    m_sum   = 8'h00;
    m_we    = 1'b0;
  endtask

  task automatic checkModel();
    checkOutput("busy",      32'(busy),      32'(m_phase == P_LOAD || m_phase == P_CHECK));
    checkOutput("done",      32'(done),      32'(m_phase == P_DONE));
    checkOutput("error",     32'(error),     32'(m_phase == P_ERR));
    checkOutput("cpu_rst_n", 32'(cpu_rst_n), 32'(m_phase == P_DONE));
    checkOutput("count",     32'(count),     32'(m_count));
    checkOutput("mem_we",    32'(mem_we),    32'(m_we));
    if (m_we) begin
      checkOutput("mem_addr",  32'(mem_addr),  32'(m_waddr));
      checkOutput("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
    if (mem_we) n_writes++;
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks the result at the next falling edge.
  task automatic applyStimulus(input bit st, input int ln, input bit ab, input bit v, input logic [7:0] d);
    start      = st;
    len        = AW'(ln);
    abort      = ab;
    byte_valid = v;
    byte_data  = d;
    #1;
    checkOutput("byte_ready", 32'(byte_ready), 32'((m_phase == P_LOAD || m_phase == P_CHECK) && !ab));
    @(posedge clk);
    modelStep(st, ln, ab, v, d);
    @(negedge clk);
    start      = 1'b0;
    abort      = 1'b0;
    byte_valid = 1'b0;
    checkModel();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         w0;
    int         ln;
    int         abort_at;
    bit         v;
    bit         st;
    logic [7:0] d;

    total = 0;
    bad = 0;
    n_writes = 0;
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    abort = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    modelReset();

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkModel();
    checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst_mem_addr",   32'(mem_addr),   32'd0);
    checkOutput("rst_mem_wdata",  32'(mem_wdata),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: 4-byte load, oversize, empty, start-vs-abort, abort priority.
    tbl.push_back('{1'b1, 4,  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0});
    tbl.push_back('{1'b0, 0,  1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'hFF, 1});
    tbl.push_back('{1'b0, 0,  1'b0, 1'b1, 8'hC4, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'hC4, 2});
    tbl.push_back('{1'b0, 0,  1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 2, 8'hA3, 3});
`ifdef IMEM_LOADER_CHECKSUM_EN
    tbl.push_back('{1'b0, 0,  1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 3, 8'h03, 4});
    tbl.push_back('{1'b0, 0,  1'b0, 1'b1, 8'h69, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 4});
`else
    tbl.push_back('{1'b0, 0,  1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 3, 8'h03, 4});
`endif
    tbl.push_back('{1'b0, 0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 4});
    tbl.push_back('{1'b1, 65, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 0});
    tbl.push_back('{1'b0, 0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 0});
    tbl.push_back('{1'b1, 0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 0});
    tbl.push_back('{1'b1, 64, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0});
    tbl.push_back('{1'b0, 0,  1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0});
    tbl.push_back('{1'b0, 0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].st, tbl[i].ln, tbl[i].ab, tbl[i].v, tbl[i].d);
      checkOutput($sformatf("row%0d_busy", i),   32'(busy),   32'(tbl[i].e_busy));
      checkOutput($sformatf("row%0d_done", i),   32'(done),   32'(tbl[i].e_done));
      checkOutput($sformatf("row%0d_error", i),  32'(error),  32'(tbl[i].e_err));
      checkOutput($sformatf("row%0d_cpurst", i), 32'(cpu_rst_n), 32'(tbl[i].e_done));
      checkOutput($sformatf("row%0d_we", i),     32'(mem_we), 32'(tbl[i].e_we));
      checkOutput($sformatf("row%0d_count", i),  32'(count),  32'(tbl[i].e_cnt));
      if (tbl[i].e_we) begin
        checkOutput($sformatf("row%0d_addr", i), 32'(mem_addr),  32'(tbl[i].e_addr));
        checkOutput($sformatf("row%0d_data", i), 32'(mem_wdata), 32'(tbl[i].e_data));
      end
    end

    // len=8 with byte_valid toggling every other cycle.
    w0 = n_writes;
    applyStimulus(1'b1, 8, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 0, 1'b0, (i % 2) == 1, 8'(8'hA0 + i));
    end
    if (CSUM) applyStimulus(1'b0, 0, 1'b0, 1'b1, m_sum);
    checkOutput("toggle_writes", 32'(n_writes - w0), 32'd8);
    checkOutput("toggle_done",   32'(done),          32'd1);

    // Abort after 3 of 8 bytes, with a byte offered in the abort cycle.
    w0 = n_writes;
    applyStimulus(1'b1, 8, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h10);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h20);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h30);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 8'h40);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h50);
    checkOutput("abort_writes", 32'(n_writes - w0), 32'd3);
    checkOutput("abort_count",  32'(count),         32'd3);
    checkOutput("abort_busy",   32'(busy),          32'd0);

    // Reset pulse while a write strobe is pending.
    applyStimulus(1'b1, 8, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h22);
    byte_valid = 1'b1;
    byte_data  = 8'h33;
    @(posedge clk);
    #1;
    checkOutput("prerst_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_we",     32'(mem_we),     32'd0);
    checkOutput("midrst_busy",   32'(busy),       32'd0);
    checkOutput("midrst_count",  32'(count),      32'd0);
    checkOutput("midrst_addr",   32'(mem_addr),   32'd0);
    checkOutput("midrst_wdata",  32'(mem_wdata),  32'd0);
    checkOutput("midrst_cpurst", 32'(cpu_rst_n),  32'd0);
    checkOutput("midrst_ready",  32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h44);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum byte correct, then incorrect.
    w0 = n_writes;
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h02);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h03);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h06);
    checkOutput("csum_ok_done",   32'(done),          32'd1);
    checkOutput("csum_ok_writes", 32'(n_writes - w0), 32'd3);
    w0 = n_writes;
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h02);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h03);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 8'h07);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 8'h00);
    checkOutput("csum_bad_error",  32'(error),         32'd1);
    checkOutput("csum_bad_writes", 32'(n_writes - w0), 32'd3);
`endif

    // Random sessions against the reference model.
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 7) == 0) ln = int'($urandom_range(65, 80));
      else                           ln = int'($urandom_range(0, 64));
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 40)) : -1;
      applyStimulus(1'b1, ln, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 400 && (m_phase == P_LOAD || m_phase == P_CHECK); c++) begin
        v  = 1'($urandom_range(0, 1));
        st = ($urandom_range(0, 15) == 0);
        if (m_phase == P_CHECK && $urandom_range(0, 1) == 1) d = m_sum;
        else                                                  d = 8'($urandom);
        applyStimulus(st, int'($urandom_range(0, 70)), c == abort_at, v, d);
      end
      if (m_phase == P_LOAD || m_phase == P_CHECK) begin
        checkOutput("rand_session_bound", 32'(m_phase), 32'(P_DONE));
      end
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_BUS_WIDTH, default 16: width of mem_addr, matching the instruction memory address bus.
REQ-002 Parameter MEM_BYTES, default 64: byte capacity of the instruction memory being loaded.
REQ-003 Parameter BASE_ADDR, default 0: address of the first byte written in every load session.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to begin a load session.
REQ-008 len  in  ADDR_BUS_WIDTH  payload byte count, sampled only when start is accepted.
REQ-009 abort  in  1  cancels an active session.
REQ-010 byte_valid  in  1  a byte is offered on byte_data.
REQ-011 byte_data  in  8  incoming program byte, big-endian instruction order.
REQ-012 byte_ready  out  1  loader accepts byte_data this cycle.
REQ-013 mem_we  out  1  one-cycle write strobe to the instruction memory.
REQ-014 mem_addr  out  ADDR_BUS_WIDTH  byte address for the write.
REQ-015 mem_wdata  out  8  byte to be written.
REQ-016 cpu_rst_n  out  1  active-low hold of the processor core; 1 only in DONE.
REQ-017 busy, done, error  out  1 each  status flags, one-hot with IDLE (all 0).
REQ-018 count  out  ADDR_BUS_WIDTH  payload bytes accepted in the current session.

Function
REQ-019 States: IDLE, LOAD, CHECK (macro only), DONE, ERROR. busy=1 in LOAD and CHECK.
REQ-020 A handshake occurs on any cycle where byte_valid and byte_ready are both 1. byte_ready is 1 only in LOAD and CHECK.
REQ-021 start is accepted in IDLE, DONE or ERROR, and ignored in LOAD and CHECK. On acceptance, count clears and the address counter loads BASE_ADDR.
REQ-022 Start with len=0 goes to DONE next cycle with no writes.
REQ-023 Start with BASE_ADDR+len > MEM_BYTES goes to ERROR next cycle with no writes.
REQ-024 Otherwise start goes to LOAD.
REQ-025 Each handshake in LOAD produces, on the following cycle:
- mem_we=1;
- mem_addr = address counter value at the handshake;
- mem_wdata = the accepted byte.
- Latency is exactly 1 cycle; mem_we is otherwise 0.
REQ-026 The address counter and count increment by 1 per LOAD handshake.
REQ-027 On the handshake that makes count equal len, the next state is CHECK if the macro is defined, else DONE. The final write strobe still issues.
REQ-028 abort in LOAD or CHECK goes to IDLE next cycle. No further mem_we is issued after the abort edge, except a strobe already owed from a handshake in the same cycle. abort has priority over byte handshakes.
REQ-029 Simultaneous start and abort in IDLE, DONE or ERROR: start wins.
REQ-030 The address counter and count wrap modulo 2^ADDR_BUS_WIDTH; unreachable in practice because of REQ-023.

Reset
REQ-031 On rst_n low: state=IDLE; mem_we, byte_ready, busy, done, error=0; cpu_rst_n=0; count, mem_addr, mem_wdata=0; checksum accumulator=0.
REQ-032 Reset asserted mid-session abandons the session immediately, and any pending write strobe is dropped.

Configuration
REQ-033 With IMEM_LOADER_CHECKSUM_EN defined:
- an 8-bit modulo-256 sum of payload bytes accumulates during LOAD;
- CHECK accepts exactly one extra byte, which is not written to memory;
- that byte equal to the sum goes to DONE, otherwise to ERROR.
REQ-034 Without IMEM_LOADER_CHECKSUM_EN, there is no CHECK state and no accumulator, and ERROR arises only from REQ-023.

Structure
REQ-035 State encoding localparams and the status-flag layout go in shared package imem_loader_pkg.
REQ-036 No sub-module. The FSM, counters and checksum are in one module.

Verification
REQ-037 len=4, bytes FF C4 A3 03 with byte_valid held high -> mem_we on 4 consecutive cycles at addr 0..3 with those data; done=1; cpu_rst_n=1.
REQ-038 len=8 with byte_valid toggling every other cycle -> 8 writes, addr 0..7, each exactly 1 cycle after its handshake.
REQ-039 len=65 with MEM_BYTES=64 -> error=1 the next cycle, no mem_we, cpu_rst_n=0.
REQ-040 abort after 3 of 8 bytes -> 3 writes total, state IDLE, count stays 3, busy=0.
REQ-041 rst_n pulsed low during LOAD -> all outputs at reset values immediately, no further mem_we.
REQ-042 Macro defined, bytes 01 02 03 then checksum 06 -> done. Checksum 07 instead -> error; 3 writes, no write of the checksum byte.
